// File: rtl/mac_sequencer_if.sv
// Handshake and control bundle between the MAC sequencer, the operand
// source / result sink and the MAC datapath register cells.
interface mac_sequencer_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic             acc_clr;
    logic             acc_load;
    logic             out_load;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] tap_idx;
    logic             busy;
    logic             done;

    modport master (
        input  start, abort, in_valid, out_ready,
        output in_ready, acc_clr, acc_load, out_load,
        output out_valid, tap_idx, busy, done
    );

    modport slave (
        output start, abort, in_valid, out_ready,
        input  in_ready, acc_clr, acc_load, out_load,
        input  out_valid, tap_idx, busy, done
    );
endinterface

// File: rtl/mac_sequencer.sv
// Control FSM sequencing one N_TAPS dot-product through the MAC datapath:
// clear, gated accumulate, capture, then hold the result for downstream.
module mac_sequencer #(
    parameter int N_TAPS = 8,
    parameter int CNT_W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        FLUSH,
        WAIT_OUT
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS - 1);

    state_t           state;
    logic [CNT_W-1:0] tap_q;
    logic             acc_clr_q;
    logic             in_ready_q;
    logic             out_load_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             accept;

    assign accept = in_ready_q & bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tap_q       <= '0;
            acc_clr_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_load_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort beats any accept or result handshake in the same cycle
            if (bus.abort && state != IDLE) begin
                state       <= IDLE;
                tap_q       <= '0;
                acc_clr_q   <= 1'b0;
                in_ready_q  <= 1'b0;
                out_load_q  <= 1'b0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state     <= CLEAR;
                            acc_clr_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state      <= ACCUM;
                        tap_q      <= '0;
                        acc_clr_q  <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                    ACCUM: begin
                        if (accept) begin
                            if (tap_q == LAST) begin
                                state      <= FLUSH;
                                tap_q      <= '0;
                                in_ready_q <= 1'b0;
                                out_load_q <= 1'b1;
                            end else begin
                                tap_q <= tap_q + 1'b1;
                            end
                        end
                    end
                    FLUSH: begin
                        state       <= WAIT_OUT;
                        out_load_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                    WAIT_OUT: begin
                        if (bus.out_ready) begin
                            state       <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Loads are qualified by abort so an aborted cycle never disturbs the bank
    assign bus.acc_load  = accept & ~bus.abort;
    assign bus.out_load  = out_load_q & ~bus.abort;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.tap_idx   = tap_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: an 8-tap and a 1-tap instance share stimulus and
// are checked each cycle against a counter-based model plus literal checks.
module tb_mac_sequencer;
    logic clk;
    logic rst_n;
    logic start;
    logic abort;
    logic in_valid;
    logic out_ready;

    int compared;
    int mismatched;

    mac_sequencer_if #(.CNT_W(3)) b0 ();
    mac_sequencer_if #(.CNT_W(1)) b1 ();

    assign b0.start     = start;
    assign b0.abort     = abort;
    assign b0.in_valid  = in_valid;
    assign b0.out_ready = out_ready;
    assign b1.start     = start;
    assign b1.abort     = abort;
    assign b1.in_valid  = in_valid;
    assign b1.out_ready = out_ready;

    mac_sequencer #(.N_TAPS(8), .CNT_W(3)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    mac_sequencer #(.N_TAPS(1), .CNT_W(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: a running flag, clear flag, accepted-tap count and result hold
    int  ntaps [2] = '{8, 1};
    bit  run   [2];
    bit  clring[2];
    bit  hold  [2];
    bit  dn    [2];
    int  taps  [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                run[k]    <= 1'b0;
                clring[k] <= 1'b0;
                hold[k]   <= 1'b0;
                dn[k]     <= 1'b0;
                taps[k]   <= 0;
            end else begin
                dn[k] <= 1'b0;
                if (abort && run[k]) begin
                    run[k]    <= 1'b0;
                    clring[k] <= 1'b0;
                    hold[k]   <= 1'b0;
                    taps[k]   <= 0;
                end else if (!run[k]) begin
                    if (start) begin
                        run[k]    <= 1'b1;
                        clring[k] <= 1'b1;
                        taps[k]   <= 0;
                    end
                end else if (clring[k]) begin
                    clring[k] <= 1'b0;
                end else if (taps[k] < ntaps[k]) begin
                    if (in_valid) taps[k] <= taps[k] + 1;
                end else if (!hold[k]) begin
                    hold[k] <= 1'b1;
                end else if (out_ready) begin
                    run[k]  <= 1'b0;
                    hold[k] <= 1'b0;
                    taps[k] <= 0;
                    dn[k]   <= 1'b1;
                end
            end
        end
    end

    function automatic logic [9:0] model_vec(input int k);
        bit acc;
        bit fl;
        logic [2:0] t;
        acc = run[k] && !clring[k] && taps[k] < ntaps[k];
        fl  = run[k] && !clring[k] && taps[k] == ntaps[k] && !hold[k];
        t   = acc ? 3'(taps[k]) : 3'd0;
        return {run[k] && clring[k], acc && in_valid && !abort,
                fl && !abort, hold[k], acc, run[k], dn[k], t};
    endfunction

    always @(negedge clk) begin
        chk("model_dut0",
            {b0.acc_clr, b0.acc_load, b0.out_load, b0.out_valid,
             b0.in_ready, b0.busy, b0.done, b0.tap_idx},
            model_vec(0));
        chk("model_dut1",
            {b1.acc_clr, b1.acc_load, b1.out_load, b1.out_valid,
             b1.in_ready, b1.busy, b1.done, 2'b00, b1.tap_idx},
            model_vec(1));
    end

    task automatic go();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = !b0.busy && !b1.busy;
        end
        if (!ok) chk("timeout_idle", 32'd0, 32'd1);
    endtask

    task automatic wait_ov();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = b0.out_valid;
        end
        if (!ok) chk("timeout_out_valid", 32'd0, 32'd1);
    endtask

    initial begin
        int loads;
        int last_ld;
        int gap;
        bit seen;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(b0.busy), 32'd0);
        chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
        chk("rst_tap", 32'(b0.tap_idx), 32'd0);
        rst_n = 1'b1;

        // Full-rate run; dut1 (N_TAPS=1) follows the short schedule
        @(posedge clk);
        #1 start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("t1_acc_clr", 32'(b0.acc_clr), 32'(c == 1));
            chk("t1_acc_load", 32'(b0.acc_load), 32'(c >= 2 && c <= 9));
            chk("t1_tap", 32'(b0.tap_idx),
                (c >= 2 && c <= 9) ? 32'(c - 2) : 32'd0);
            chk("t1_out_load", 32'(b0.out_load), 32'(c == 10));
            chk("t1_out_valid", 32'(b0.out_valid), 32'(c == 11));
            chk("t1_done", 32'(b0.done), 32'(c == 12));
            chk("t1_busy", 32'(b0.busy), 32'(c >= 1 && c <= 11));
            if (c <= 5) begin
                chk("t6_acc_load", 32'(b1.acc_load), 32'(c == 2));
                chk("t6_out_load", 32'(b1.out_load), 32'(c == 3));
                chk("t6_out_valid", 32'(b1.out_valid), 32'(c == 4));
                chk("t6_done", 32'(b1.done), 32'(c == 5));
            end
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Alternating IN_VALID during accumulation
        in_valid = 1'b0;
        go();
        loads = 0; last_ld = 0; gap = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1 in_valid = ~in_valid;
            @(negedge clk);
            if (b0.acc_load) begin
                loads++;
                last_ld = i;
            end
            if (b0.out_load) begin
                seen = 1'b1;
                gap  = i - last_ld;
            end
        end
        chk("t2_loads", 32'(loads), 32'd8);
        chk("t2_flush_gap", 32'(gap), 32'd1);
        in_valid = 1'b0;
        wait_idle();

        // Downstream back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        go();
        wait_ov();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(b0.out_valid), 32'd1);
            chk("t3_no_ready", 32'(b0.in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_done", 32'(b0.done), 32'd1);
        chk("t3_idle", 32'(b0.busy), 32'd0);
        @(posedge clk);
        #1;
        chk("t3_done_pulse", 32'(b0.done), 32'd0);
        wait_idle();

        // Abort with TAP_IDX=3 while IN_VALID is high
        go();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        #1;
        chk("t4_tap3", 32'(b0.tap_idx), 32'd3);
        chk("t4_no_load", 32'(b0.acc_load), 32'd0);
        @(posedge clk);
        #1 abort = 1'b0;
        chk("t4_busy", 32'(b0.busy), 32'd0);
        chk("t4_tap0", 32'(b0.tap_idx), 32'd0);
        chk("t4_no_done", 32'(b0.done), 32'd0);
        go();
        chk("t4_restart_clr", 32'(b0.acc_clr), 32'd1);
        wait_idle();

        // Asynchronous reset in WAIT_OUT, then START ignored in ACCUM
        out_ready = 1'b0;
        go();
        wait_ov();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(b0.out_valid), 32'd0);
        chk("t5_async_busy", 32'(b0.busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        go();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 start = 1'b1;
        #1;
        chk("t5_no_clr", 32'(b0.acc_clr), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("t5_tap_cont", 32'(b0.tap_idx), 32'd2);
        chk("t5_still_accum", 32'(b0.in_ready), 32'd1);
        wait_idle();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
